acc_job_scheduler: RTL and testbench

// - Sequences the shared FIR / matmul / sorting accelerator between three job requesters (one per kernel).
// - Latches job requests, picks one round-robin, and drives the one-hot ap_start into the accelerator.
// - Tracks the output stream (sm_*) to completion, enforces a watchdog, and reports per-kernel done/error.
// - Sits between the CPU-facing config/DMA control logic and the accelerator.

---
 rtl/acc_pkg.sv | 27 ++
 rtl/acc_job_scheduler_if.sv | 25 ++
 rtl/acc_rr_arbiter.sv | 31 +++
 rtl/acc_job_scheduler.sv | 152 +++++++++++++++
 tb/tb_acc_job_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the accelerator job scheduler: kernel encodings,
// FSM states, default job lengths and a small ring-index helper.
package acc_pkg;

  // One-hot kernel identifiers, also used directly as ap_start values
  localparam logic [2:0] K_FIR  = 3'b001;
  localparam logic [2:0] K_MAT  = 3'b010;
  localparam logic [2:0] K_SORT = 3'b100;

  // Default number of output beats each kernel produces per job
  localparam int DEF_LEN_FIR    = 64;
  localparam int DEF_LEN_MATMUL = 16;
  localparam int DEF_LEN_SORT   = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RUN,
    S_DRAIN
  } sched_state_e;

  // Next index on the three-entry ring (2 wraps back to 0)
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/acc_job_scheduler_if.sv
// Control/stream bundle between the scheduler and the shared accelerator.
// The scheduler only drives ap_start; the stream signals are observed.
interface acc_job_scheduler_if;
  logic [2:0] ap_start;
  logic       ap_idle;
  logic       sm_tvalid;
  logic       sm_tready;
  logic       sm_tlast;

  modport master (
    output ap_start,
    input  ap_idle,
    input  sm_tvalid,
    input  sm_tready,
    input  sm_tlast
  );

  modport slave (
    input  ap_start,
    output ap_idle,
    output sm_tvalid,
    output sm_tready,
    output sm_tlast
  );
endinterface

// File: rtl/acc_rr_arbiter.sv
// Three-way round-robin picker: returns the first pending kernel at or
// after the pointer index. Purely combinational; the owner keeps the pointer.
module acc_rr_arbiter
  import acc_pkg::*;
(
  input  logic [2:0] pending_i,
  input  logic [1:0] ptr_i,
  output logic [2:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       grant_vld_o
);

  logic [1:0] cand;

  // Walk the ring from the pointer and stop at the first pending entry
  always_comb begin
    grant_o     = 3'b000;
    grant_idx_o = ptr_i;
    grant_vld_o = 1'b0;
    cand        = ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (!grant_vld_o && pending_i[cand]) begin
        grant_vld_o = 1'b1;
        grant_idx_o = cand;
        grant_o     = 3'b001 << cand;
      end
      cand = rr_next(cand);
    end
  end

endmodule

// File: rtl/acc_job_scheduler.sv
// Job scheduler for the shared FIR / matmul / sort accelerator. Latches
// requests, grants round-robin, pulses ap_start, watches the output stream
// for completion or stall, and reports done/error per kernel.
module acc_job_scheduler
  import acc_pkg::*;
#(
  parameter int LEN_FIR    = DEF_LEN_FIR,
  parameter int LEN_MATMUL = DEF_LEN_MATMUL,
  parameter int LEN_SORT   = DEF_LEN_SORT,
  parameter int TIMEOUT    = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_i,
  output logic [2:0]          pending_o,
  output logic                busy_o,
  output logic [2:0]          cur_job_o,
  output logic [2:0]          job_done_o,
  output logic [2:0]          job_err_o,
  acc_job_scheduler_if.master acc_if
);

  localparam int IW = $clog2(TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  sched_state_e  state_q;
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    cur_job_q;
  logic [1:0]    cur_idx_q;
  logic [1:0]    rr_ptr_q;
  logic          busy_q;
  logic [2:0]    ap_start_q;
  logic [2:0]    job_done_q;
  logic [2:0]    job_err_q;
  logic          err_q;
  logic [6:0]    beat_cnt_q;
  logic [6:0]    exp_len_q;
  logic [IW-1:0] idle_cnt_q;

  logic [2:0]    grant;
  logic [1:0]    grant_idx;
  logic          grant_vld;
  logic          do_grant;
  logic          beat;

  function automatic logic [6:0] len_of(input logic [2:0] kern);
    case (kern)
      K_FIR:   return 7'(LEN_FIR);
      K_MAT:   return 7'(LEN_MATMUL);
      K_SORT:  return 7'(LEN_SORT);
      default: return 7'd0;
    endcase
  endfunction

  acc_rr_arbiter u_arb (
    .pending_i   (pending_q),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_vld_o (grant_vld)
  );

  assign beat     = acc_if.sm_tvalid & acc_if.sm_tready;
  assign do_grant = (state_q == S_IDLE) && grant_vld && acc_if.ap_idle;

  // Granted bit drops, then new requests (including one for the job just granted) set bits
  always_comb begin
    pending_d = pending_q;
    if (do_grant) pending_d = pending_d & ~grant;
    pending_d = pending_d | req_i;
  end

  // Pending request register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= 3'b000;
    else        pending_q <= pending_d;
  end

  // Job sequencing FSM with registered handshake, status and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cur_job_q  <= 3'b000;
      cur_idx_q  <= 2'd0;
      rr_ptr_q   <= 2'd0;
      busy_q     <= 1'b0;
      ap_start_q <= 3'b000;
      job_done_q <= 3'b000;
      job_err_q  <= 3'b000;
      err_q      <= 1'b0;
      beat_cnt_q <= 7'd0;
      exp_len_q  <= 7'd0;
      idle_cnt_q <= '0;
    end else begin
      job_done_q <= 3'b000;
      job_err_q  <= 3'b000;
      case (state_q)
        S_IDLE: begin
          if (do_grant) begin
            state_q    <= S_ISSUE;
            cur_job_q  <= grant;
            cur_idx_q  <= grant_idx;
            busy_q     <= 1'b1;
            ap_start_q <= grant;
            exp_len_q  <= len_of(grant);
            beat_cnt_q <= 7'd0;
            idle_cnt_q <= '0;
            err_q      <= 1'b0;
          end
        end
        S_ISSUE: begin
          ap_start_q <= 3'b000;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          if (beat) begin
            if (beat_cnt_q != 7'h7F) beat_cnt_q <= beat_cnt_q + 7'd1;
            idle_cnt_q <= '0;
            if (acc_if.sm_tlast) begin
              err_q   <= ((beat_cnt_q + 7'd1) != exp_len_q);
              state_q <= S_DRAIN;
            end
          end else if (idle_cnt_q == IDLE_MAX) begin
            err_q   <= 1'b1;
            state_q <= S_DRAIN;
          end else begin
            idle_cnt_q <= idle_cnt_q + IW'(1);
          end
        end
        S_DRAIN: begin
          if (acc_if.ap_idle) begin
            if (err_q) job_err_q  <= cur_job_q;
            else       job_done_q <= cur_job_q;
            rr_ptr_q  <= rr_next(cur_idx_q);
            cur_job_q <= 3'b000;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign pending_o       = pending_q;
  assign busy_o          = busy_q;
  assign cur_job_o       = cur_job_q;
  assign job_done_o      = job_done_q;
  assign job_err_o       = job_err_q;
  assign acc_if.ap_start = ap_start_q;

endmodule

// File: tb/tb_acc_job_scheduler.sv
// Directed bench for acc_job_scheduler. The bench plays the accelerator:
// it drops ap_idle after each start, streams beats and raises ap_idle again.
module tb_acc_job_scheduler;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] pending;
  logic       busy;
  logic [2:0] cur_job;
  logic [2:0] job_done;
  logic [2:0] job_err;

  int checks = 0;
  int failures = 0;

  acc_job_scheduler_if acc_if ();

  acc_job_scheduler #(
    .LEN_FIR    (64),
    .LEN_MATMUL (16),
    .LEN_SORT   (10),
    .TIMEOUT    (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .pending_o  (pending),
    .busy_o     (busy),
    .cur_job_o  (cur_job),
    .job_done_o (job_done),
    .job_err_o  (job_err),
    .acc_if     (acc_if)
  );

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  // Advance one cycle and settle just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req              = 3'b000;
    acc_if.ap_idle   = 1'b1;
    acc_if.sm_tvalid = 1'b0;
    acc_if.sm_tready = 1'b1;
    acc_if.sm_tlast  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Bounded wait for a start pulse; returns 0 if none appears
  task automatic wait_start(output logic [2:0] seen);
    seen = 3'b000;
    for (int i = 0; i < 40 && seen == 3'b000; i++) begin
      tick();
      seen = acc_if.ap_start;
    end
  endtask

  // Stream n beats, asserting tlast on beat number last_at (0 = never)
  task automatic drive_beats(input int n, input int last_at);
    for (int b = 1; b <= n; b++) begin
      acc_if.sm_tvalid = 1'b1;
      acc_if.sm_tlast  = (b == last_at);
      tick();
    end
    acc_if.sm_tvalid = 1'b0;
    acc_if.sm_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    req              = 3'b000;
    acc_if.ap_idle   = 1'b1;
    acc_if.sm_tvalid = 1'b0;
    acc_if.sm_tready = 1'b1;
    acc_if.sm_tlast  = 1'b0;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({pending, busy, cur_job, job_done, job_err, acc_if.ap_start} !== 16'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got pend=%b busy=%b cur=%b done=%b err=%b start=%b, expected all 0",
               pending, busy, cur_job, job_done, job_err, acc_if.ap_start);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_fir();
    apply_reset();
    req = K_FIR;
    tick();
    req = 3'b000;
    checks++;
    if (pending !== 3'b001 || acc_if.ap_start !== 3'b000) begin
      failures++;
      $display("[TB] FAIL fir_latch: got pend=%b start=%b expected pend=001 start=000", pending, acc_if.ap_start);
    end
    tick();
    checks++;
    if (acc_if.ap_start !== 3'b001 || busy !== 1'b1 || cur_job !== 3'b001 || pending !== 3'b000) begin
      failures++;
      $display("[TB] FAIL fir_issue: got start=%b busy=%b cur=%b pend=%b expected 001 1 001 000",
               acc_if.ap_start, busy, cur_job, pending);
    end
    acc_if.ap_idle = 1'b0;
    tick();
    checks++;
    if (acc_if.ap_start !== 3'b000) begin
      failures++;
      $display("[TB] FAIL fir_start_width: got %b expected 000", acc_if.ap_start);
    end
    drive_beats(64, 64);
    tick();
    checks++;
    if (job_done !== 3'b000 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fir_drain_wait: got done=%b busy=%b expected 000 1", job_done, busy);
    end
    acc_if.ap_idle = 1'b1;
    tick();
    checks++;
    if (job_done !== 3'b001 || job_err !== 3'b000 || busy !== 1'b0 || cur_job !== 3'b000) begin
      failures++;
      $display("[TB] FAIL fir_done: got done=%b err=%b busy=%b cur=%b expected 001 000 0 000",
               job_done, job_err, busy, cur_job);
    end
    tick();
    checks++;
    if (job_done !== 3'b000) begin
      failures++;
      $display("[TB] FAIL fir_done_pulse: got %b expected 000", job_done);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] kern [3];
    int         lens [3];
    logic [2:0] seen;
    kern = '{K_FIR, K_MAT, K_SORT};
    lens = '{64, 16, 10};
    apply_reset();
    req = 3'b111;
    tick();
    req = 3'b000;
    checks++;
    if (pending !== 3'b111) begin
      failures++;
      $display("[TB] FAIL simul_pending: got %b expected 111", pending);
    end
    for (int j = 0; j < 3; j++) begin
      wait_start(seen);
      checks++;
      if (seen !== kern[j]) begin
        failures++;
        $display("[TB] FAIL simul_order_%0d: got start=%b expected %b", j, seen, kern[j]);
      end
      acc_if.ap_idle = 1'b0;
      tick();
      drive_beats(lens[j], lens[j]);
      acc_if.ap_idle = 1'b1;
      tick();
      checks++;
      if (job_done !== kern[j] || acc_if.ap_start !== 3'b000) begin
        failures++;
        $display("[TB] FAIL simul_done_%0d: got done=%b start=%b expected done=%b start=000",
                 j, job_done, acc_if.ap_start, kern[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seen;
    apply_reset();
    req = K_FIR;
    tick();
    req = 3'b000;
    wait_start(seen);
    acc_if.ap_idle = 1'b0;
    tick();
    drive_beats(64, 64);
    acc_if.ap_idle = 1'b1;
    tick();
    checks++;
    if (job_done !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rr_fir_done: got %b expected 001", job_done);
    end
    req = K_FIR | K_MAT;
    tick();
    req = 3'b000;
    checks++;
    if (pending !== 3'b011) begin
      failures++;
      $display("[TB] FAIL rr_pending: got %b expected 011", pending);
    end
    wait_start(seen);
    checks++;
    if (seen !== 3'b010) begin
      failures++;
      $display("[TB] FAIL rr_first_grant: got %b expected 010", seen);
    end
    acc_if.ap_idle = 1'b0;
    tick();
    drive_beats(16, 16);
    acc_if.ap_idle = 1'b1;
    tick();
    wait_start(seen);
    checks++;
    if (seen !== 3'b001) begin
      failures++;
      $display("[TB] FAIL rr_second_grant: got %b expected 001", seen);
    end
  endtask

  task automatic test_length_mismatch();
    logic [2:0] seen;
    apply_reset();
    req = K_MAT;
    tick();
    req = 3'b000;
    wait_start(seen);
    acc_if.ap_idle = 1'b0;
    tick();
    drive_beats(12, 12);
    tick();
    acc_if.ap_idle = 1'b1;
    tick();
    checks++;
    if (job_err !== 3'b010 || job_done !== 3'b000) begin
      failures++;
      $display("[TB] FAIL mismatch_err: got err=%b done=%b expected 010 000", job_err, job_done);
    end
    tick();
    checks++;
    if (job_err !== 3'b000 || job_done !== 3'b000) begin
      failures++;
      $display("[TB] FAIL mismatch_pulse: got err=%b done=%b expected 000 000", job_err, job_done);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] seen;
    apply_reset();
    req = K_SORT;
    tick();
    req = 3'b000;
    wait_start(seen);
    checks++;
    if (seen !== 3'b100) begin
      failures++;
      $display("[TB] FAIL timeout_start: got %b expected 100", seen);
    end
    acc_if.ap_idle = 1'b0;
    tick();
    drive_beats(3, 0);
    acc_if.ap_idle = 1'b1;
    req = K_FIR;
    tick();
    req = 3'b000;
    for (int i = 0; i < 31; i++) tick();
    checks++;
    if (job_err !== 3'b000 || busy !== 1'b1 || pending !== 3'b001) begin
      failures++;
      $display("[TB] FAIL timeout_early: got err=%b busy=%b pend=%b expected 000 1 001", job_err, busy, pending);
    end
    tick();
    checks++;
    if (job_err !== 3'b100 || job_done !== 3'b000) begin
      failures++;
      $display("[TB] FAIL timeout_err: got err=%b done=%b expected 100 000", job_err, job_done);
    end
    tick();
    checks++;
    if (acc_if.ap_start !== 3'b001) begin
      failures++;
      $display("[TB] FAIL timeout_next_job: got start=%b expected 001", acc_if.ap_start);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] seen;
    logic [2:0] pulses;
    apply_reset();
    req = K_FIR;
    tick();
    req = 3'b000;
    wait_start(seen);
    acc_if.ap_idle = 1'b0;
    tick();
    drive_beats(20, 0);
    req = K_SORT;
    tick();
    req = 3'b000;
    checks++;
    if (busy !== 1'b1 || pending !== 3'b100) begin
      failures++;
      $display("[TB] FAIL areset_pre: got busy=%b pend=%b expected 1 100", busy, pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || acc_if.ap_start !== 3'b000 || pending !== 3'b000 || cur_job !== 3'b000) begin
      failures++;
      $display("[TB] FAIL areset_clear: got busy=%b start=%b pend=%b cur=%b expected 0 000 000 000",
               busy, acc_if.ap_start, pending, cur_job);
    end
    pulses = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      pulses = pulses | job_done | job_err;
    end
    rst_n = 1'b1;
    acc_if.ap_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      pulses = pulses | job_done | job_err;
    end
    checks++;
    if (pulses !== 3'b000 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL areset_no_pulse: got pulses=%b busy=%b expected 000 0", pulses, busy);
    end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_single_fir();
    test_simultaneous();
    test_round_robin();
    test_length_mismatch();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
